// File: rtl/fp8_pkg.sv
// Shared FP8 (E4M3) / BF16 field definitions for the FP8 multiply datapath.
// Contents: field widths, exponent biases, BF16 special encodings, the bf16_t
// payload struct and a helper that prepends the hidden mantissa bit.
package fp8_pkg;

    localparam int unsigned FP8_EXP_W   = 4;
    localparam int unsigned FP8_MAN_W   = 3;
    localparam int unsigned BF16_EXP_W  = 8;
    localparam int unsigned BF16_FRAC_W = 7;
    localparam int unsigned BF16_W      = 1 + BF16_EXP_W + BF16_FRAC_W;
    localparam int unsigned MANT_W      = BF16_FRAC_W + 1;
    localparam int unsigned PROD_W      = 2 * MANT_W;
    localparam int unsigned EXP_SUM_W   = 10;

    localparam int unsigned FP8_BIAS  = 7;
    localparam int unsigned BF16_BIAS = 127;

    localparam logic [BF16_W-1:0]     BF16_QNAN    = 16'h7FC0;
    localparam logic [BF16_EXP_W-1:0] BF16_INF_EXP = 8'hFF;

    typedef struct packed {
        logic                   sign;
        logic [BF16_EXP_W-1:0]  exp;
        logic [BF16_FRAC_W-1:0] frac;
    } bf16_t;

    // Significand with the implicit leading one restored.
    function automatic logic [MANT_W-1:0] hidden_mant(input logic [BF16_FRAC_W-1:0] frac);
        return {1'b1, frac};
    endfunction

endpackage

// File: rtl/bf16_normalize_special.sv
// Combinational final stage: normalise the 16-bit significand product and
// select special results.
// Ports: sign, prod (8x8 significand product), exp_sum (biased exponent sum,
// signed), is_zero / is_inf (either operand), result (BF16 out).
module bf16_normalize_special
    import fp8_pkg::*;
(
    input  logic                        sign,
    input  logic [PROD_W-1:0]           prod,
    input  logic signed [EXP_SUM_W-1:0] exp_sum,
    input  logic                        is_zero,
    input  logic                        is_inf,
    output bf16_t                       result
);

    logic [BF16_FRAC_W-1:0]      frac;
    logic signed [EXP_SUM_W-1:0] exp_adj;
    logic                        unused_bits;

    // Product of two [1,2) significands lies in [1,4): at most one bit of shift.
    // Operands carry <=3 fraction bits each, so the dropped low bits are always zero.
    always_comb begin
        frac    = prod[13:7];
        exp_adj = exp_sum;
        if (prod[15]) begin
            frac    = prod[14:8];
            exp_adj = exp_sum + 10'sd1;
        end
    end

    // 0*inf is invalid and wins over both inf and zero.
    always_comb begin
        result = '{sign: sign, exp: exp_adj[BF16_EXP_W-1:0], frac: frac};
        if (is_zero && is_inf) begin
            result = bf16_t'(BF16_QNAN);
        end else if (is_inf) begin
            result = '{sign: sign, exp: BF16_INF_EXP, frac: '0};
        end else if (is_zero) begin
            result = '{sign: sign, exp: '0, frac: '0};
        end
    end

    assign unused_bits = ^{prod[6:0], exp_adj[EXP_SUM_W-1:BF16_EXP_W]};

endmodule

// File: rtl/fp8_to_bf16_decoder.sv
// Combinational E4M3 -> BF16 operand decoder.
// Ports: fp8 (E4M3 operand in), val (BF16 fields out), is_zero / is_inf (class flags).
// Exponent field 4'hF is treated as infinity regardless of mantissa; subnormals
// either flush to signed zero (FTZ=1) or are renormalised into BF16 (FTZ=0).
module fp8_to_bf16_decoder
    import fp8_pkg::*;
#(
    parameter bit FTZ = 1'b1
) (
    input  logic [7:0] fp8,
    output bf16_t      val,
    output logic       is_zero,
    output logic       is_inf
);

    logic [FP8_EXP_W-1:0] exp_f;
    logic [FP8_MAN_W-1:0] man_f;

    assign exp_f = fp8[6:3];
    assign man_f = fp8[2:0];

    // Field decode; exact because BF16 has more exponent and fraction bits than E4M3.
    always_comb begin
        val      = '0;
        is_zero  = 1'b0;
        is_inf   = 1'b0;
        val.sign = fp8[7];
        if (exp_f == '1) begin
            is_inf = 1'b1;
        end else if (exp_f == '0) begin
            if ((man_f == '0) || FTZ) begin
                is_zero = 1'b1;
            end else if (man_f[2]) begin
                val.exp  = BF16_EXP_W'(BF16_BIAS - FP8_BIAS);
                val.frac = {man_f[1:0], 5'b0};
            end else if (man_f[1]) begin
                val.exp  = BF16_EXP_W'(BF16_BIAS - FP8_BIAS - 1);
                val.frac = {man_f[0], 6'b0};
            end else begin
                val.exp  = BF16_EXP_W'(BF16_BIAS - FP8_BIAS - 2);
                val.frac = '0;
            end
        end else begin
            val.exp  = BF16_EXP_W'(exp_f) + BF16_EXP_W'(BF16_BIAS - FP8_BIAS);
            val.frac = {man_f, 4'b0};
        end
    end

endmodule

// File: rtl/fp8_mul_bf16_pipe.sv
// Pipelined E4M3 x E4M3 multiplier with an exact BF16 product.
// Ports: clk, rst_n (async, active low), flush (sync clear of in-flight ops),
// in_valid/in_ready/in_a/in_b (operand handshake), out_valid/out_ready/out_bf16
// (product handshake). Result appears after edge N+3 for an op accepted at edge N.
// Ranks: operand capture -> decode (S1) -> multiply (S2) -> normalise/out (S3).
// All ranks advance together; a stalled output freezes the whole pipe.
module fp8_mul_bf16_pipe
    import fp8_pkg::*;
#(
    parameter bit          FTZ_FP8 = 1'b1,
    parameter int unsigned WIDTH   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BF16_W-1:0] out_bf16
);

    logic advance;

    // Operand capture rank
    logic             v0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;

    // S1: decoded operands
    logic                  v1;
    logic                  sign1;
    logic [BF16_EXP_W-1:0] ea1;
    logic [BF16_EXP_W-1:0] eb1;
    logic [MANT_W-1:0]     ma1;
    logic [MANT_W-1:0]     mb1;
    logic                  zero1;
    logic                  inf1;

    // S2: raw product
    logic                        v2;
    logic                        sign2;
    logic [PROD_W-1:0]           prod2;
    logic signed [EXP_SUM_W-1:0] exp2;
    logic                        zero2;
    logic                        inf2;

    bf16_t                       dec_a;
    bf16_t                       dec_b;
    logic                        za;
    logic                        zb;
    logic                        ia;
    logic                        ib;
    logic [PROD_W-1:0]           prod_c;
    logic signed [EXP_SUM_W-1:0] exp_sum_c;
    bf16_t                       norm_c;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !flush;

    fp8_to_bf16_decoder #(.FTZ(FTZ_FP8)) u_dec_a (
        .fp8     (a0),
        .val     (dec_a),
        .is_zero (za),
        .is_inf  (ia)
    );

    fp8_to_bf16_decoder #(.FTZ(FTZ_FP8)) u_dec_b (
        .fp8     (b0),
        .val     (dec_b),
        .is_zero (zb),
        .is_inf  (ib)
    );

    assign prod_c    = PROD_W'(ma1) * PROD_W'(mb1);
    assign exp_sum_c = $signed(EXP_SUM_W'(ea1)) + $signed(EXP_SUM_W'(eb1))
                     - $signed(EXP_SUM_W'(BF16_BIAS));

    bf16_normalize_special u_norm (
        .sign    (sign2),
        .prod    (prod2),
        .exp_sum (exp2),
        .is_zero (zero2),
        .is_inf  (inf2),
        .result  (norm_c)
    );

    // Pipeline registers; flush drops valids only so out_bf16 keeps its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0        <= 1'b0;
            a0        <= '0;
            b0        <= '0;
            v1        <= 1'b0;
            sign1     <= 1'b0;
            ea1       <= '0;
            eb1       <= '0;
            ma1       <= '0;
            mb1       <= '0;
            zero1     <= 1'b0;
            inf1      <= 1'b0;
            v2        <= 1'b0;
            sign2     <= 1'b0;
            prod2     <= '0;
            exp2      <= '0;
            zero2     <= 1'b0;
            inf2      <= 1'b0;
            out_valid <= 1'b0;
            out_bf16  <= '0;
        end else if (flush) begin
            v0        <= 1'b0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            v0        <= in_valid;
            a0        <= in_a;
            b0        <= in_b;

            v1        <= v0;
            sign1     <= dec_a.sign ^ dec_b.sign;
            ea1       <= dec_a.exp;
            eb1       <= dec_b.exp;
            ma1       <= hidden_mant(dec_a.frac);
            mb1       <= hidden_mant(dec_b.frac);
            zero1     <= za || zb;
            inf1      <= ia || ib;

            v2        <= v1;
            sign2     <= sign1;
            prod2     <= prod_c;
            exp2      <= exp_sum_c;
            zero2     <= zero1;
            inf2      <= inf1;

            out_valid <= v2;
            if (v2) begin
                out_bf16 <= norm_c;
            end
        end
    end

endmodule

// File: tb/tb_fp8_mul_bf16_pipe.sv
// Self-checking bench for fp8_mul_bf16_pipe: vector table, latency, stall,
// flush and async-reset sequences, then a random stream against a reference model.
module tb_fp8_mul_bf16_pipe;

    localparam bit FTZ = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bf16;

    always #5 clk = ~clk;

    fp8_mul_bf16_pipe #(.FTZ_FP8(FTZ), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bf16  (out_bf16)
    );

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        logic [15:0] exp;
        int          acc_cyc;
    } sb_t;

    vec_t        vecs[14];
    sb_t         sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          n_pop = 0;
    bit          check_lat = 1'b0;
    bit          use_tbl   = 1'b0;
    logic [15:0] tbl_exp;
    bit          hold_pending = 1'b0;
    logic [15:0] hold_val;
    logic        last_ov;
    logic        last_ir;
    logic        last_acc;
    logic [15:0] last_bf;
    logic [15:0] saved_bf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void dec(input logic [7:0] x, output int m, output int e,
                                output bit z, output bit i);
        i = (x[6:3] == 4'hF);
        z = (x[6:3] == 4'h0) && (FTZ || (x[2:0] == 3'd0));
        if (x[6:3] == 4'h0) begin
            m = int'(x[2:0]);
            e = -9;
        end else begin
            m = 8 + int'(x[2:0]);
            e = int'(x[6:3]) - 10;
        end
    endfunction

    // Value = M * 2^E with integer M; renormalise to 1.fff * 2^k.
    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int ma, mb, ea, eb, m, e, p;
        bit za, zb, ia, ib, s;
        logic [7:0] ex;
        logic [6:0] fr;
        s = a[7] ^ b[7];
        dec(a, ma, ea, za, ia);
        dec(b, mb, eb, zb, ib);
        if ((za || zb) && (ia || ib)) return 16'h7FC0;
        if (ia || ib) return {s, 8'hFF, 7'h0};
        if (za || zb) return {s, 15'h0};
        m = ma * mb;
        e = ea + eb;
        p = 7;
        while (p > 0 && ((m >> p) & 1) == 0) p--;
        assert (p <= 7 && m < 256) else $error("product significand exceeds 8 bits");
        ex = 8'(e + p + 127);
        fr = 7'((m - (1 << p)) << (7 - p));
        return {s, ex, fr};
    endfunction

    // One cycle: observe at negedge, score handshakes, then advance past posedge.
    task automatic step();
        sb_t e;
        bit  fire;
        @(negedge clk);
        last_ov  = out_valid;
        last_ir  = in_ready;
        last_bf  = out_bf16;
        last_acc = in_valid && in_ready;
        chk("in_ready", 32'(in_ready), 32'((!out_valid || out_ready) && !flush));
        if (hold_pending) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", 32'(out_bf16), 32'(hold_val));
        end
        hold_pending = out_valid && !out_ready && !flush;
        hold_val     = out_bf16;
        fire = out_valid && out_ready && !flush;
        if (fire) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 32'(out_bf16), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                n_pop++;
                chk("product", 32'(out_bf16), 32'(e.exp));
                if (check_lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd4);
            end
        end
        if (flush) sb.delete();
        if (last_acc) begin
            e.exp     = use_tbl ? tbl_exp : ref_mul(in_a, in_b);
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) step();
        step();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    logic [7:0] ra;
    logic [7:0] rb;

    initial begin
        vecs[0]  = '{8'h38, 8'h38, 16'h3F80};
        vecs[1]  = '{8'h3C, 8'h3C, 16'h4010};
        vecs[2]  = '{8'hB8, 8'h40, 16'hC000};
        vecs[3]  = '{8'h77, 8'h77, 16'h4761};
        vecs[4]  = '{8'h78, 8'h40, 16'h7F80};
        vecs[5]  = '{8'h78, 8'h00, 16'h7FC0};
        vecs[6]  = '{8'h80, 8'h38, 16'h8000};
        vecs[7]  = '{8'h01, 8'h38, 16'h0000};
        vecs[8]  = '{8'h08, 8'h08, 16'h3980};
        vecs[9]  = '{8'hF8, 8'h38, 16'hFF80};
        vecs[10] = '{8'hF8, 8'h80, 16'h7FC0};
        vecs[11] = '{8'h80, 8'h80, 16'h0000};
        vecs[12] = '{8'h01, 8'hB8, 16'h8000};
        vecs[13] = '{8'h77, 8'hF7, 16'hC761};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bf16", 32'(out_bf16), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op latency: valid only after the fourth edge following accept
        check_lat = 1'b1;
        in_valid = 1'b1; in_a = 8'h38; in_b = 8'h38;
        step();
        chk("lat_accept", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("lat_out_valid", 32'(last_ov), 32'(k == 4));
        end
        chk("lat_out_bf16", 32'(last_bf), 32'h3F80);
        drain();

        // Vector table, back to back
        use_tbl = 1'b1;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_a     = vecs[i].a;
            in_b     = vecs[i].b;
            tbl_exp  = vecs[i].exp;
            for (int t = 0; t < 10; t++) begin
                step();
                if (last_acc) break;
            end
            if (!last_acc) chk("tbl_accept_timeout", 32'd0, 32'd1);
        end
        use_tbl = 1'b0;
        drain();

        // Stall: 8 ops back to back, out_ready low for cycles 4-6
        check_lat = 1'b0;
        n_pop = 0;
        begin
            int idx = 0;
            for (int j = 0; j < 40 && (idx < 8 || sb.size() > 0); j++) begin
                in_valid  = (idx < 8);
                in_a      = vecs[idx % 8].a;
                in_b      = vecs[idx % 8].b;
                out_ready = !(j >= 4 && j <= 6);
                step();
                if (j >= 4 && j <= 6) begin
                    chk("stall_out_valid", 32'(last_ov), 32'd1);
                    chk("stall_in_ready", 32'(last_ir), 32'd0);
                end
                if (last_acc) idx++;
            end
        end
        drain();
        chk("stall_count", 32'(n_pop), 32'd8);

        // Flush with 3 ops in flight and a competing input
        check_lat = 1'b1;
        saved_bf = out_bf16;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_a = vecs[i + 1].a;
            in_b = vecs[i + 1].b;
            step();
        end
        flush = 1'b1;
        in_valid = 1'b1; in_a = 8'h3C; in_b = 8'h3C;
        step();
        chk("flush_in_ready", 32'(last_ir), 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flush_out_valid", 32'(last_ov), 32'd0);
        chk("flush_keep_bf16", 32'(last_bf), 32'(saved_bf));
        in_valid = 1'b1; in_a = 8'hB8; in_b = 8'h40;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("post_flush_valid", 32'(last_ov), 32'(k == 4));
        end
        chk("post_flush_bf16", 32'(last_bf), 32'hC000);
        drain();

        // Async reset mid-stream
        check_lat = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = vecs[i].a;
            in_b = vecs[i].b;
            step();
        end
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_bf16", 32'(out_bf16), 32'd0);
        sb.delete();
        hold_pending = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Random stream against the reference model
        ra = '0;
        rb = '0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || last_acc) begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                if (ra[6:3] == 4'hF) ra[2:0] = 3'd0;
                if (rb[6:3] == 4'hF) rb[2:0] = 3'd0;
                in_valid = ($urandom_range(0, 3) != 0);
            end
            in_a = ra;
            in_b = rb;
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
